// File: rtl/capture_ctrl.sv
// capture_ctrl: capture sequencer that streams ADC samples into a circular RAM buffer around a trigger and plays them out oldest-first
// Ports:
//   clk_i, rst_n_i                         clock, asynchronous active-low reset
//   arm_i, force_trig_i, trig_level_i      capture control and trigger threshold
//   sample_valid_i, sample_i               ADC sample stream
//   ram_w_en_o, ram_w_addr_o, ram_w_data_o RAM write port
//   ram_r_addr_o, ram_r_data_i             RAM asynchronous read port
//   out_valid_o, out_ready_i, out_data_o,
//   out_last_o                             readout stream
//   busy_o, triggered_o                    status
module capture_ctrl #(
  parameter int DATA_SIZE = 12,
  parameter int ADDR_SIZE = 8,
  parameter int PRE_TRIG  = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 arm_i,
  input  logic                 force_trig_i,
  input  logic [DATA_SIZE-1:0] trig_level_i,
  input  logic                 sample_valid_i,
  input  logic [DATA_SIZE-1:0] sample_i,
  output logic                 ram_w_en_o,
  output logic [ADDR_SIZE-1:0] ram_w_addr_o,
  output logic [DATA_SIZE-1:0] ram_w_data_o,
  output logic [ADDR_SIZE-1:0] ram_r_addr_o,
  input  logic [DATA_SIZE-1:0] ram_r_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DATA_SIZE-1:0] out_data_o,
  output logic                 out_last_o,
  output logic                 busy_o,
  output logic                 triggered_o
);
  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam int POST_N = DEPTH - PRE_TRIG;
  localparam logic [ADDR_SIZE-1:0] PRE_LAST = ADDR_SIZE'(PRE_TRIG - 1);
  localparam logic [ADDR_SIZE-1:0] POST_LAST = ADDR_SIZE'(POST_N - 1);
  localparam logic [ADDR_SIZE-1:0] READ_LAST = ADDR_SIZE'(DEPTH - 1);
  typedef enum logic [2:0] {IDLE, PRE, WAIT_TRIG, POST, READ} state_t;
  state_t state;
  logic [ADDR_SIZE-1:0] w_ptr, rd_ptr, cnt;
  logic [DATA_SIZE-1:0] prev_sample;
  logic prev_valid, force_pend;
  logic writing, level_hit, trig;
  assign writing = sample_valid_i && (state == PRE || state == WAIT_TRIG || state == POST);
  assign level_hit = prev_valid && prev_sample < trig_level_i && sample_i >= trig_level_i;
  assign trig = sample_valid_i && (level_hit || force_trig_i || force_pend);
  assign ram_w_en_o = writing;
  assign ram_w_addr_o = w_ptr;
  assign ram_w_data_o = writing ? sample_i : '0;
  assign ram_r_addr_o = rd_ptr;
  assign out_valid_o = state == READ;
  assign out_data_o = out_valid_o ? ram_r_data_i : '0;
  assign out_last_o = out_valid_o && cnt == READ_LAST;
  assign busy_o = state != IDLE;
  assign triggered_o = state == POST || state == READ;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      w_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      prev_sample <= '0;
      prev_valid <= 1'b0;
      force_pend <= 1'b0;
    end else begin
      if (writing) w_ptr <= w_ptr + 1'b1;
      if (sample_valid_i && (state == PRE || state == WAIT_TRIG)) begin
        prev_sample <= sample_i;
        prev_valid <= 1'b1;
      end
      case (state)
        IDLE: if (arm_i) begin
          cnt <= '0;
          prev_valid <= 1'b0;
          state <= PRE;
        end
        PRE: if (sample_valid_i) begin
          cnt <= cnt == PRE_LAST ? '0 : cnt + 1'b1;
          if (cnt == PRE_LAST) state <= WAIT_TRIG;
        end
        WAIT_TRIG: if (trig) begin
          force_pend <= 1'b0;
          // the trigger sample is post-trigger sample #1; rd_ptr lands on the oldest entry
          if (POST_N == 1) begin
            state <= READ;
            rd_ptr <= w_ptr + 1'b1;
            cnt <= '0;
          end else begin
            state <= POST;
            cnt <= ADDR_SIZE'(1);
          end
        end else if (force_trig_i) force_pend <= 1'b1;
        POST: if (sample_valid_i) begin
          if (cnt == POST_LAST) begin
            state <= READ;
            rd_ptr <= w_ptr + 1'b1;
            cnt <= '0;
          end else cnt <= cnt + 1'b1;
        end
        READ: if (out_ready_i) begin
          rd_ptr <= rd_ptr + 1'b1;
          cnt <= cnt + 1'b1;
          if (cnt == READ_LAST) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: directed self-checking bench for capture_ctrl (DEPTH=16, PRE_TRIG=4)
module tb_capture_ctrl;
  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  logic arm_i = 1'b0, force_trig_i = 1'b0, sample_valid_i = 1'b0, out_ready_i = 1'b0;
  logic [11:0] trig_level_i = '0, sample_i = '0;
  logic ram_w_en_o, out_valid_o, out_last_o, busy_o, triggered_o;
  logic [3:0] ram_w_addr_o, ram_r_addr_o;
  logic [11:0] ram_w_data_o, ram_r_data_i, out_data_o;
  logic [11:0] mem [16];
  logic [11:0] stim [64];
  logic [3:0] wa [64];
  logic [11:0] got [16];
  logic lst [16], gv [16];
  int nw;
  int errors = 0, checks = 0;
  capture_ctrl #(.DATA_SIZE(12), .ADDR_SIZE(4), .PRE_TRIG(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .arm_i(arm_i), .force_trig_i(force_trig_i),
    .trig_level_i(trig_level_i), .sample_valid_i(sample_valid_i), .sample_i(sample_i),
    .ram_w_en_o(ram_w_en_o), .ram_w_addr_o(ram_w_addr_o), .ram_w_data_o(ram_w_data_o),
    .ram_r_addr_o(ram_r_addr_o), .ram_r_data_i(ram_r_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_last_o(out_last_o), .busy_o(busy_o), .triggered_o(triggered_o)
  );
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) if (ram_w_en_o) mem[ram_w_addr_o] <= ram_w_data_o;
  assign ram_r_data_i = mem[ram_r_addr_o];
  task automatic do_reset;
    rst_n_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
  endtask
  task automatic arm;
    arm_i = 1'b1;
    @(negedge clk_i);
    arm_i = 1'b0;
  endtask
  task automatic run_stim(input int n);
    nw = 0;
    for (int i = 0; i < n && !out_valid_o; i++) begin
      sample_valid_i = 1'b1;
      sample_i = stim[i];
      #1;
      if (ram_w_en_o) begin
        wa[nw] = ram_w_addr_o;
        nw++;
      end
      @(negedge clk_i);
    end
    sample_valid_i = 1'b0;
  endtask
  task automatic collect;
    for (int i = 0; i < 16; i++) begin
      out_ready_i = 1'b1;
      #1;
      got[i] = out_data_o;
      lst[i] = out_last_o;
      gv[i] = out_valid_o;
      @(negedge clk_i);
    end
    out_ready_i = 1'b0;
  endtask
  task automatic test_reset;
    sample_valid_i = 1'b1;
    sample_i = 12'h777;
    @(negedge clk_i);
    checks++;
    if ({ram_w_en_o, ram_w_addr_o, ram_w_data_o, ram_r_addr_o, out_valid_o, out_data_o, out_last_o, busy_o, triggered_o} !== 37'd0) begin
      errors++;
      $display("FAIL reset_outputs got w_en=%b w_addr=%h w_data=%h r_addr=%h valid=%b data=%h last=%b busy=%b trig=%b exp all 0",
        ram_w_en_o, ram_w_addr_o, ram_w_data_o, ram_r_addr_o, out_valid_o, out_data_o, out_last_o, busy_o, triggered_o);
    end
    rst_n_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({busy_o, ram_w_en_o} !== 2'b00) begin
      errors++;
      $display("FAIL idle_no_write got busy=%b w_en=%b exp 0 0", busy_o, ram_w_en_o);
    end
    sample_valid_i = 1'b0;
  endtask
  task automatic test_ramp;
    trig_level_i = 12'd10;
    for (int i = 0; i < 64; i++) stim[i] = 12'(i);
    arm_i = 1'b1;
    @(negedge clk_i);
    run_stim(64);
    arm_i = 1'b0;
    checks++;
    if (nw !== 22) begin errors++; $display("FAIL ramp_writes got=%0d exp=22", nw); end
    checks++;
    if ({busy_o, triggered_o} !== 2'b11) begin errors++; $display("FAIL ramp_status got=%b%b exp=11", busy_o, triggered_o); end
    collect;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({gv[i], lst[i], got[i]} !== {1'b1, i == 15, 12'(6 + i)}) begin
        errors++;
        $display("FAIL ramp_rd[%0d] got v=%b l=%b d=%0d exp v=1 l=%b d=%0d", i, gv[i], lst[i], got[i], i == 15, 6 + i);
      end
    end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL ramp_idle got busy=%b exp=0", busy_o); end
  endtask
  task automatic test_wrap;
    do_reset;
    trig_level_i = 12'd18;
    for (int i = 0; i < 64; i++) stim[i] = 12'(i);
    arm;
    run_stim(64);
    checks++;
    if (nw !== 30) begin errors++; $display("FAIL wrap_pre_writes got=%0d exp=30", nw); end
    collect;
    checks++;
    if ({got[0], got[15]} !== {12'd14, 12'd29}) begin errors++; $display("FAIL wrap_pre_rd got=%0d,%0d exp=14,29", got[0], got[15]); end
    trig_level_i = 12'd8;
    arm;
    run_stim(64);
    checks++;
    if (nw !== 20) begin errors++; $display("FAIL wrap_writes got=%0d exp=20", nw); end
    checks++;
    if ({wa[0], wa[1], wa[2]} !== {4'd14, 4'd15, 4'd0}) begin
      errors++;
      $display("FAIL wrap_addr got=%0d,%0d,%0d exp=14,15,0", wa[0], wa[1], wa[2]);
    end
    collect;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({gv[i], lst[i], got[i]} !== {1'b1, i == 15, 12'(4 + i)}) begin
        errors++;
        $display("FAIL wrap_rd[%0d] got v=%b l=%b d=%0d exp v=1 l=%b d=%0d", i, gv[i], lst[i], got[i], i == 15, 4 + i);
      end
    end
  endtask
  task automatic test_force;
    trig_level_i = 12'd10;
    for (int i = 0; i < 64; i++) stim[i] = 12'd50;
    arm;
    run_stim(7);
    checks++;
    if (nw !== 7) begin errors++; $display("FAIL force_pre_writes got=%0d exp=7", nw); end
    force_trig_i = 1'b1;
    @(negedge clk_i);
    force_trig_i = 1'b0;
    checks++;
    if ({busy_o, triggered_o} !== 2'b10) begin errors++; $display("FAIL force_wait1 got=%b%b exp=10", busy_o, triggered_o); end
    @(negedge clk_i);
    checks++;
    if ({busy_o, triggered_o} !== 2'b10) begin errors++; $display("FAIL force_wait2 got=%b%b exp=10", busy_o, triggered_o); end
    run_stim(40);
    checks++;
    if (nw !== 12) begin errors++; $display("FAIL force_post_writes got=%0d exp=12", nw); end
    collect;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({gv[i], lst[i], got[i]} !== {1'b1, i == 15, 12'd50}) begin
        errors++;
        $display("FAIL force_rd[%0d] got v=%b l=%b d=%0d exp v=1 l=%b d=50", i, gv[i], lst[i], got[i], i == 15);
      end
    end
  endtask
  task automatic test_level_first;
    logic [11:0] s4 [10] = '{12'd5, 12'd15, 12'd20, 12'd20, 12'd20, 12'd20, 12'd20, 12'd3, 12'd9, 12'd12};
    logic [11:0] e4 [5] = '{12'd20, 12'd20, 12'd3, 12'd9, 12'd12};
    logic [11:0] e;
    trig_level_i = 12'd10;
    for (int i = 0; i < 64; i++) stim[i] = i < 10 ? s4[i] : 12'(100 + i - 10);
    arm;
    run_stim(64);
    checks++;
    if (nw !== 21) begin errors++; $display("FAIL level_writes got=%0d exp=21", nw); end
    collect;
    for (int i = 0; i < 16; i++) begin
      e = i < 5 ? e4[i] : 12'(100 + i - 5);
      checks++;
      if ({gv[i], lst[i], got[i]} !== {1'b1, i == 15, e}) begin
        errors++;
        $display("FAIL level_rd[%0d] got v=%b l=%b d=%0d exp v=1 l=%b d=%0d", i, gv[i], lst[i], got[i], i == 15, e);
      end
    end
  endtask
  task automatic test_backpressure;
    int rp [4] = '{1, 0, 0, 1};
    logic [3:0] ea [4] = '{4'd6, 4'd7, 4'd7, 4'd7};
    do_reset;
    trig_level_i = 12'd10;
    for (int i = 0; i < 64; i++) stim[i] = 12'(i);
    arm;
    run_stim(64);
    checks++;
    if (nw !== 22) begin errors++; $display("FAIL bp_writes got=%0d exp=22", nw); end
    sample_valid_i = 1'b1;
    sample_i = 12'h0AA;
    for (int k = 0; k < 4; k++) begin
      out_ready_i = rp[k] != 0;
      #1;
      checks++;
      if ({ram_r_addr_o, out_data_o, ram_w_en_o, out_valid_o} !== {ea[k], 8'd0, ea[k], 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL bp_hold[%0d] got addr=%0d data=%0d w_en=%b valid=%b exp addr=%0d data=%0d w_en=0 valid=1",
          k, ram_r_addr_o, out_data_o, ram_w_en_o, out_valid_o, ea[k], ea[k]);
      end
      @(negedge clk_i);
    end
    for (int i = 2; i < 16; i++) begin
      out_ready_i = 1'b1;
      arm_i = i == 15;
      #1;
      checks++;
      if ({ram_r_addr_o, out_data_o, out_last_o, ram_w_en_o} !== {4'(6 + i), 12'(6 + i), i == 15, 1'b0}) begin
        errors++;
        $display("FAIL bp_rd[%0d] got addr=%0d data=%0d last=%b w_en=%b exp addr=%0d data=%0d last=%b w_en=0",
          i, ram_r_addr_o, out_data_o, out_last_o, ram_w_en_o, (6 + i) % 16, 6 + i, i == 15);
      end
      @(negedge clk_i);
    end
    arm_i = 1'b0;
    out_ready_i = 1'b0;
    sample_valid_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL bp_no_rearm got busy=%b exp=0", busy_o); end
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL bp_idle got busy=%b exp=0", busy_o); end
  endtask
  task automatic test_reset_mid;
    trig_level_i = 12'd10;
    for (int i = 0; i < 64; i++) stim[i] = 12'(i);
    arm;
    run_stim(14);
    checks++;
    if ({busy_o, triggered_o} !== 2'b11) begin errors++; $display("FAIL mid_post_status got=%b%b exp=11", busy_o, triggered_o); end
    sample_valid_i = 1'b1;
    sample_i = 12'd77;
    #2;
    rst_n_i = 1'b0;
    #1;
    checks++;
    if ({ram_w_en_o, ram_w_addr_o, ram_w_data_o, ram_r_addr_o, out_valid_o, out_data_o, out_last_o, busy_o, triggered_o} !== 37'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs got w_en=%b w_addr=%h w_data=%h r_addr=%h valid=%b data=%h last=%b busy=%b trig=%b exp all 0",
        ram_w_en_o, ram_w_addr_o, ram_w_data_o, ram_r_addr_o, out_valid_o, out_data_o, out_last_o, busy_o, triggered_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    sample_valid_i = 1'b0;
    @(negedge clk_i);
    arm;
    run_stim(64);
    checks++;
    if (nw !== 22) begin errors++; $display("FAIL mid_rearm_writes got=%0d exp=22", nw); end
    collect;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({gv[i], lst[i], got[i]} !== {1'b1, i == 15, 12'(6 + i)}) begin
        errors++;
        $display("FAIL mid_rd[%0d] got v=%b l=%b d=%0d exp v=1 l=%b d=%0d", i, gv[i], lst[i], got[i], i == 15, 6 + i);
      end
    end
  endtask
  initial begin
    test_reset;
    test_ramp;
    test_wrap;
    test_force;
    test_level_first;
    test_backpressure;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
